// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC stage: holds the fetch address, advances/redirects it,
// and tracks the address and validity of the instruction on the memory output.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] id_pc_plus4,
    output logic [31:0] ProgramCounter,
    output logic [31:0] pc_plus4,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        fetch_fault
);

    // Keeps only the word-address bits that index the instruction memory.
    localparam logic [31:0] PC_MASK = 32'(MEM_WORDS * 4 - 1) & ~32'h3;

    logic [31:0] jump_pc;
    logic [31:0] branch_pc;
    logic        branch_misaligned;
    logic        unused_id_pc_bits;

    // Redirect targets and sequential successor, all wrapped to memory depth.
    always_comb begin
        jump_pc           = {id_pc_plus4[31:28], jump_index, 2'b00} & PC_MASK;
        branch_pc         = {branch_target[31:2], 2'b00} & PC_MASK;
        branch_misaligned = |branch_target[1:0];
        pc_plus4          = (ProgramCounter + 32'd4) & PC_MASK;
    end

    assign unused_id_pc_bits = &{1'b0, id_pc_plus4[27:0]};

    // Redirects squash the wrong-path fetch; a stall freezes the whole stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            ProgramCounter <= RESET_PC & PC_MASK;
            if_pc          <= RESET_PC & PC_MASK;
            if_valid       <= 1'b0;
            fetch_fault    <= 1'b0;
        end else if (jump) begin
            ProgramCounter <= jump_pc;
            if_pc          <= ProgramCounter;
            if_valid       <= 1'b0;
        end else if (branch_taken) begin
            ProgramCounter <= branch_pc;
            if_pc          <= ProgramCounter;
            if_valid       <= 1'b0;
            fetch_fault    <= fetch_fault | branch_misaligned;
        end else if (!stall) begin
            ProgramCounter <= pc_plus4;
            if_pc          <= ProgramCounter;
            if_valid       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed test-plan steps followed by
// random stimulus, all compared against a behavioural fetch model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned MEM_WORDS = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] id_pc_plus4;
    logic [31:0] ProgramCounter;
    logic [31:0] pc_plus4;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        fetch_fault;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_if_pc;
    logic        m_valid, m_fault;

    fetch_pc_unit #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index), .id_pc_plus4(id_pc_plus4),
        .ProgramCounter(ProgramCounter), .pc_plus4(pc_plus4),
        .if_pc(if_pc), .if_valid(if_valid), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // Byte address -> aligned address inside the memory, by word arithmetic.
    function automatic logic [31:0] wrap(input logic [31:0] a);
        return 32'(((a / 32'd4) % MEM_WORDS) * 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc",          ProgramCounter, m_pc);
        chk("pc_plus4",    pc_plus4,       wrap(m_pc + 32'd4));
        chk("if_pc",       if_pc,          m_if_pc);
        chk("if_valid",    32'(if_valid),  32'(m_valid));
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    endtask

    // Apply one cycle of inputs, advance the model, clock, then compare.
    task automatic step(input logic r, input logic s, input logic b,
                        input logic [31:0] bt, input logic j,
                        input logic [25:0] ji, input logic [31:0] ip);
        reset = r; stall = s; branch_taken = b; branch_target = bt;
        jump = j; jump_index = ji; id_pc_plus4 = ip;
        if (r) begin
            m_pc = wrap(RESET_PC); m_if_pc = wrap(RESET_PC);
            m_valid = 1'b0; m_fault = 1'b0;
        end else if (j) begin
            m_if_pc = m_pc;
            m_pc    = wrap({ip[31:28], ji, 2'b00});
            m_valid = 1'b0;
        end else if (b) begin
            m_if_pc = m_pc;
            m_pc    = wrap(bt);
            m_valid = 1'b0;
            if (bt % 4 != 0) m_fault = 1'b1;
        end else if (!s) begin
            m_if_pc = m_pc;
            m_pc    = wrap(m_pc + 32'd4);
            m_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
    endtask

    task automatic do_branch(input logic [31:0] t);
        step(1'b0, 1'b0, 1'b1, t, 1'b0, 26'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        jump = 1'b0; jump_index = 26'd0; id_pc_plus4 = 32'd0;

        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
        chk("reset_pc", ProgramCounter, 32'd0);

        free_run(3);
        chk("run_pc12", ProgramCounter, 32'd12);
        chk("run_ifpc8", if_pc, 32'd8);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
        chk("stall_pc", ProgramCounter, 32'd12);
        chk("stall_ifpc", if_pc, 32'd8);

        free_run(1);
        chk("resume_pc16", ProgramCounter, 32'd16);
        free_run(1);

        do_branch(32'd8);
        chk("br_pc8", ProgramCounter, 32'd8);
        chk("br_squash", 32'(if_valid), 32'd0);
        free_run(1);
        chk("br_tgt_ifpc", if_pc, 32'd8);

        // Jump beats branch and stall on the same edge.
        step(1'b0, 1'b1, 1'b1, 32'd40, 1'b1, 26'h3, 32'd0);
        chk("jump_pc12", ProgramCounter, 32'd12);

        do_branch(32'd120);
        free_run(2);
        chk("wrap_pc0", ProgramCounter, 32'd0);

        do_branch(32'd34);
        chk("mis_pc32", ProgramCounter, 32'd32);
        chk("mis_fault", 32'(fetch_fault), 32'd1);
        free_run(3);
        do_branch(32'd60);

        // Reset during a stall at PC=60.
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
        chk("rst_stall_pc", ProgramCounter, 32'd0);
        chk("rst_stall_fault", 32'(fetch_fault), 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 $urandom(),
                 ($urandom_range(0, 7) == 0),
                 26'($urandom()),
                 $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
